dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Data-memory-side responder for the single-cycle CPU. It serves the CPU's daddr/dwdata/we_dmem requests and returns drdata in the same cycle.
- Contains a word-organised RAM with byte-lane writes and a small MMIO region. The MMIO region holds a console TX FIFO with a valid/ready drain port, a status register, and a free-running cycle counter.
- Sits beside the CPU in the top-level testbench/SoC wrapper. The instruction memory stays a separate block.

Parameters:
- DMEM_WORDS, 1024, RAM depth in 32-bit words; power of two; RAM occupies byte addresses 0 .. DMEM_WORDS*4-1.
- MMIO_BASE, 32'h8000_0000, byte base address of the MMIO register block.
- FIFO_DEPTH, 8, console FIFO entries; power of two, 2..128.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- daddr  in  32  byte address from CPU; daddr[1:0] ignored (word-aligned access).
- dwdata  in  32  write data from CPU, lane-aligned.
- we_dmem  in  4  per-byte write enables; bit i writes dwdata[8i+7:8i].
- drdata  out  32  read data to CPU, combinational from daddr and current state.
- cons_data  out  8  byte at FIFO head.
- cons_valid  out  1  high when FIFO non-empty.
- cons_ready  in  1  sink accepts cons_data on an edge where cons_valid and cons_ready are both high.
- addr_err  out  1  registered one-cycle pulse, raised after any write (we_dmem != 0) to an unmapped address.

Behaviour:
- Clock and reset: one clock (clk); reset asynchronous, active-high; all registers below clear immediately on reset assertion.
- Reset values:
  - FIFO empty, so cons_valid=0; cons_data=0 while empty.
  - overflow sticky flag 0, cycle counter 0, addr_err 0.
  - RAM contents are NOT reset.
  - drdata follows the read mux with the reset state.
- Decode, using word address A = {daddr[31:2],2'b00}:
  - RAM: A < DMEM_WORDS*4; word index = daddr[log2(DMEM_WORDS)+1:2].
  - TXDATA: A = MMIO_BASE+0x0.
  - STATUS: A = MMIO_BASE+0x4.
  - CYCLE: A = MMIO_BASE+0x8.
  - Everything else is unmapped.
- Reads (zero latency, combinational):
  - RAM returns the stored word.
  - TXDATA reads 32'h0.
  - STATUS = {16'h0, count[7:0], 5'h0, overflow, empty, full}. count is the FIFO occupancy, zero-extended to 8 bits.
  - CYCLE returns the counter value.
  - Unmapped returns 32'h0.
  - A read in the same cycle as a write to the same location returns the OLD value; the new value is visible next cycle.
- RAM writes: on the rising edge, each enabled byte lane is updated; lanes with a 0 enable are unchanged.
- TXDATA write, only when we_dmem[0]=1 (other lanes ignored):
  - Pushes dwdata[7:0].
  - If the FIFO is full and no pop happens on the same edge: the byte is dropped and overflow is set to 1.
  - If full and a pop happens on the same edge: the push is accepted, count is unchanged, and overflow is not set.
- FIFO drain:
  - cons_valid = (count != 0); cons_data = head entry.
  - A pop occurs on an edge where cons_valid && cons_ready.
  - Push into an empty FIFO: cons_valid rises after that edge. There is no same-cycle bypass from dwdata to cons_data.
  - Pointers wrap modulo FIFO_DEPTH. count is 0..FIFO_DEPTH and is held in log2(FIFO_DEPTH)+1 bits.
- STATUS write: when we_dmem[0]=1 and dwdata[2]=1, overflow clears. If an overflow event occurs on the same edge, the set wins. All other bits are read-only.
- CYCLE counter:
  - Increments by 1 every edge and wraps 32'hFFFF_FFFF -> 0.
  - A write with we_dmem=4'hF loads dwdata; the counter reads dwdata on the next cycle and resumes incrementing after that.
  - Partial-lane writes to CYCLE are ignored, but they are not errors.
- addr_err: registered; it is 1 for exactly the cycle after each edge on which we_dmem != 0 to an unmapped address, otherwise 0. Unmapped writes modify no state.
- Reset mid-operation: FIFO contents are discarded and the pointers cleared; an in-flight handshake is abandoned (cons_valid drops asynchronously).

Test Plan:
- Reset then RAM access: write 32'hDEADBEEF to 0x10 with we=4'hF, then write 32'h000000AA with we=4'b0001 -> reading 0x10 returns 32'hDEADBEAA; reading 0x12 returns the same word.
- Console push/drain: cons_ready=0, write 0x41,0x42,0x43 to TXDATA -> STATUS=32'h0000_0300; raise cons_ready -> cons_data 0x41,0x42,0x43 on consecutive cycles, then cons_valid=0 and STATUS=32'h0000_0002.
- FIFO full and overflow: cons_ready=0, 9 writes (0x00..0x08) -> STATUS=32'h0000_0805; drained bytes are 0x00..0x07; STATUS write 32'h4 clears bit2.
- Simultaneous push/pop at full: FIFO full, cons_ready=1 on the same edge as a write of 0x55 -> count stays 8, overflow stays 0, 0x55 is drained last.
- Cycle counter: write 32'hFFFF_FFFE to CYCLE with we=4'hF -> reads 0xFFFF_FFFE, 0xFFFF_FFFF, 0x0 on successive cycles; we=4'b0011 write leaves counting unaffected.
- Unmapped and async reset: write to 0x4000_0000 -> addr_err high for exactly one cycle, reads 0; assert reset mid-cycle with FIFO non-empty -> cons_valid=0 and CYCLE=0 immediately, RAM data preserved.

Source files
------------

// File: rtl/dmem_responder_if.sv
// CPU data-port and console-drain signals shared by the data-memory responder
// and whatever drives it (CPU model or testbench).
interface dmem_responder_if;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic [3:0]  we_dmem;
    logic [31:0] drdata;
    logic [7:0]  cons_data;
    logic        cons_valid;
    logic        cons_ready;
    logic        addr_err;

    modport master (
        output daddr, dwdata, we_dmem, cons_ready,
        input  drdata, cons_data, cons_valid, addr_err
    );

    modport slave (
        input  daddr, dwdata, we_dmem, cons_ready,
        output drdata, cons_data, cons_valid, addr_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: zero-latency word RAM with byte-lane writes, plus an
// MMIO block holding a console TX FIFO, a status register and a cycle counter.
module dmem_responder #(
    parameter int          DMEM_WORDS = 1024,
    parameter logic [31:0] MMIO_BASE  = 32'h8000_0000,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic            clk,
    input  logic            reset,
    dmem_responder_if.slave bus
);
    localparam int          AW          = $clog2(DMEM_WORDS);
    localparam int          PW          = $clog2(FIFO_DEPTH);
    localparam logic [31:0] RAM_BYTES   = 32'(DMEM_WORDS * 4);
    localparam logic [31:0] TXDATA_ADDR = MMIO_BASE;
    localparam logic [31:0] STATUS_ADDR = MMIO_BASE + 32'h4;
    localparam logic [31:0] CYCLE_ADDR  = MMIO_BASE + 32'h8;
    localparam logic [PW:0] FULL_COUNT  = (PW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_RAM,
        SEL_TXDATA,
        SEL_STATUS,
        SEL_CYCLE
    } sel_e;

    logic [31:0]   r_mem [DMEM_WORDS];
    logic [7:0]    r_fifo [FIFO_DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [PW:0]   r_count;
    logic          r_overflow;
    logic [31:0]   r_cycle;
    logic          r_addr_err;

    sel_e          w_sel;
    logic [31:0]   w_word_addr;
    logic [AW-1:0] w_ram_idx;
    logic          w_any_we;
    logic          w_empty;
    logic          w_full;
    logic          w_pop;
    logic          w_push_req;
    logic          w_push;
    logic          w_ovf_set;
    logic          w_ovf_clr;
    logic          w_cycle_load;
    logic [7:0]    w_count8;
    logic [31:0]   w_rdata;
    logic          w_unused_addr_bits;

    assign w_word_addr        = {bus.daddr[31:2], 2'b00};
    assign w_ram_idx          = bus.daddr[AW+1:2];
    assign w_unused_addr_bits = &{1'b0, bus.daddr[1:0]};

    // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        w_sel = SEL_NONE;
        if (w_word_addr < RAM_BYTES)         w_sel = SEL_RAM;
        else if (w_word_addr == TXDATA_ADDR) w_sel = SEL_TXDATA;
        else if (w_word_addr == STATUS_ADDR) w_sel = SEL_STATUS;
        else if (w_word_addr == CYCLE_ADDR)  w_sel = SEL_CYCLE;
    end

    assign w_any_we     = |bus.we_dmem;
    assign w_empty      = (r_count == '0);
    assign w_full       = (r_count == FULL_COUNT);
    assign w_pop        = !w_empty && bus.cons_ready;
    assign w_push_req   = (w_sel == SEL_TXDATA) && bus.we_dmem[0];
    // A push into a full FIFO still lands when the sink frees a slot on the same edge.
    assign w_push       = w_push_req && (!w_full || w_pop);
    assign w_ovf_set    = w_push_req && w_full && !w_pop;
    assign w_ovf_clr    = (w_sel == SEL_STATUS) && bus.we_dmem[0] && bus.dwdata[2];
    assign w_cycle_load = (w_sel == SEL_CYCLE) && (bus.we_dmem == 4'hF);
    assign w_count8     = 8'(r_count);

    // NOTE: RAM and FIFO storage arrays carry no reset; only the pointers and count define FIFO contents.
    always_ff @(posedge clk) begin
        if (w_sel == SEL_RAM) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.we_dmem[i]) r_mem[w_ram_idx][8*i +: 8] <= bus.dwdata[8*i +: 8];
            end
        end
        if (w_push) r_fifo[r_wr_ptr] <= bus.dwdata[7:0];
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_cycle    <= '0;
            r_addr_err <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PW + 1)'(1);
                2'b01:   r_count <= r_count - (PW + 1)'(1);
                default: r_count <= r_count;
            endcase

            if (w_ovf_set)      r_overflow <= 1'b1;
            else if (w_ovf_clr) r_overflow <= 1'b0;

            r_cycle    <= w_cycle_load ? bus.dwdata : r_cycle + 32'd1;
            r_addr_err <= w_any_we && (w_sel == SEL_NONE);
        end
    end

    always_comb begin
        w_rdata = '0;
        case (w_sel)
            SEL_RAM:    w_rdata = r_mem[w_ram_idx];
            SEL_STATUS: w_rdata = {16'h0, w_count8, 5'h0, r_overflow, w_empty, w_full};
            SEL_CYCLE:  w_rdata = r_cycle;
            default:    w_rdata = '0;
        endcase
    end

    assign bus.drdata     = w_rdata;
    assign bus.cons_valid = !w_empty;
    assign bus.cons_data  = w_empty ? 8'h00 : r_fifo[r_rd_ptr];
    assign bus.addr_err   = r_addr_err;
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed scenarios followed by a randomized phase,
// all checked against a queue/array reference model of the memory map.
module tb_dmem_responder;
    localparam logic [31:0] BASE = 32'h8000_0000;
    localparam logic [31:0] TXA  = BASE;
    localparam logic [31:0] STA  = BASE + 32'h4;
    localparam logic [31:0] CYA  = BASE + 32'h8;
    localparam logic [31:0] UNM  = 32'h4000_0000;

    logic clk = 1'b0;
    logic reset;
    int   n_pass   = 0;
    int   n_checks = 0;

    dmem_responder_if bus();

    dmem_responder #(
        .DMEM_WORDS(1024),
        .MMIO_BASE (BASE),
        .FIFO_DEPTH(8)
    ) u_dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Reference model: the memory map as plain data structures.
    bit [31:0] m_mem [int unsigned];
    bit [7:0]  m_q[$];
    bit        m_ovf;
    bit [31:0] m_cycle;
    bit        m_err;

    function automatic bit is_mapped(input logic [31:0] a);
        return (a < 32'd4096) || (a == TXA) || (a == STA) || (a == CYA);
    endfunction

    function automatic bit exp_rd(input logic [31:0] addr, output logic [31:0] v);
        logic [31:0] a;
        a = {addr[31:2], 2'b00};
        v = '0;
        if (a < 32'd4096) begin
            if (!m_mem.exists(a >> 2)) return 1'b0;
            v = m_mem[a >> 2];
        end else if (a == STA) begin
            v = {16'h0, 8'(m_q.size()), 5'h0, m_ovf, (m_q.size() == 0), (m_q.size() == 8)};
        end else if (a == CYA) begin
            v = m_cycle;
        end
        return 1'b1;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_ovf   = 1'b0;
        m_cycle = '0;
        m_err   = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic [3:0] we);
        bus.daddr   = a;
        bus.dwdata  = d;
        bus.we_dmem = we;
    endtask

    // Apply the current request to the model, then advance one clock edge.
    task automatic tick();
        logic [31:0] a;
        bit          full, pop, push_req;
        bit [31:0]   w;
        a        = {bus.daddr[31:2], 2'b00};
        full     = (m_q.size() == 8);
        pop      = (m_q.size() != 0) && bus.cons_ready;
        push_req = (a == TXA) && bus.we_dmem[0];
        if (a < 32'd4096) begin
            w = m_mem.exists(a >> 2) ? m_mem[a >> 2] : 32'h0;
            for (int i = 0; i < 4; i++)
                if (bus.we_dmem[i]) w[8*i +: 8] = bus.dwdata[8*i +: 8];
            if (bus.we_dmem != 4'h0) m_mem[a >> 2] = w;
        end
        if (push_req && full && !pop)                       m_ovf = 1'b1;
        else if (a == STA && bus.we_dmem[0] && bus.dwdata[2]) m_ovf = 1'b0;
        if (pop) void'(m_q.pop_front());
        if (push_req && (!full || pop)) m_q.push_back(bus.dwdata[7:0]);
        m_cycle = (a == CYA && bus.we_dmem == 4'hF) ? bus.dwdata : m_cycle + 32'd1;
        m_err   = (bus.we_dmem != 4'h0) && !is_mapped(a);
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] we);
        drive(a, d, we);
        tick();
        bus.we_dmem = 4'h0;
    endtask

    task automatic chk_rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
        bus.daddr   = a;
        bus.we_dmem = 4'h0;
        #1;
        chk(tag, bus.drdata, exp);
    endtask

    task automatic chk_model(input string tag);
        logic [31:0] v;
        if (exp_rd(bus.daddr, v)) chk({tag, "_rd"}, bus.drdata, v);
        chk({tag, "_valid"}, 32'(bus.cons_valid), 32'(m_q.size() != 0));
        chk({tag, "_data"}, 32'(bus.cons_data), (m_q.size() != 0) ? 32'(m_q[0]) : 32'h0);
        chk({tag, "_err"}, 32'(bus.addr_err), 32'(m_err));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic [3:0]  we;
        int          op;

        // Reset state
        reset          = 1'b1;
        bus.cons_ready = 1'b0;
        drive(32'h0, 32'h0, 4'h0);
        model_reset();
        #12;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_valid", 32'(bus.cons_valid), 32'h0);
        chk("rst_data", 32'(bus.cons_data), 32'h0);
        chk("rst_err", 32'(bus.addr_err), 32'h0);
        chk_rd("rst_status", STA, 32'h0000_0002);
        chk_rd("rst_cycle", CYA, 32'h0);

        // RAM byte-lane writes
        wr(32'h10, 32'hDEAD_BEEF, 4'hF);
        wr(32'h10, 32'h0000_00AA, 4'b0001);
        chk_rd("ram_lane", 32'h10, 32'hDEAD_BEAA);
        chk_rd("ram_unaligned", 32'h12, 32'hDEAD_BEAA);

        // Console push/drain, no same-cycle bypass
        drive(TXA, 32'h41, 4'h1);
        #1;
        chk("no_bypass", 32'(bus.cons_valid), 32'h0);
        tick();
        wr(TXA, 32'h42, 4'h1);
        wr(TXA, 32'h43, 4'h1);
        chk_rd("cons_status3", STA, 32'h0000_0300);
        bus.cons_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("cons_drain", 32'(bus.cons_data), 32'h41 + 32'(i));
            chk("cons_drain_valid", 32'(bus.cons_valid), 32'h1);
            tick();
        end
        bus.cons_ready = 1'b0;
        #1;
        chk("cons_empty", 32'(bus.cons_valid), 32'h0);
        chk_rd("cons_status0", STA, 32'h0000_0002);

        // Full FIFO and overflow
        for (int i = 0; i < 9; i++) wr(TXA, 32'(i), 4'h1);
        chk_rd("ovf_status", STA, 32'h0000_0805);
        bus.cons_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("ovf_drain", 32'(bus.cons_data), 32'(i));
            tick();
        end
        bus.cons_ready = 1'b0;
        chk_rd("ovf_sticky", STA, 32'h0000_0006);
        wr(STA, 32'h4, 4'h1);
        chk_rd("ovf_clear", STA, 32'h0000_0002);

        // Simultaneous push and pop at full
        for (int i = 0; i < 8; i++) wr(TXA, 32'h10 + 32'(i), 4'h1);
        drive(TXA, 32'h55, 4'h1);
        bus.cons_ready = 1'b1;
        tick();
        bus.cons_ready = 1'b0;
        chk_rd("pushpop_status", STA, 32'h0000_0801);
        bus.cons_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("pushpop_drain", 32'(bus.cons_data), (i < 7) ? 32'h11 + 32'(i) : 32'h55);
            tick();
        end
        bus.cons_ready = 1'b0;
        chk_rd("pushpop_empty", STA, 32'h0000_0002);

        // Cycle counter load, wrap, partial write
        wr(CYA, 32'hFFFF_FFFE, 4'hF);
        chk_rd("cyc_load", CYA, 32'hFFFF_FFFE);
        tick();
        chk_rd("cyc_max", CYA, 32'hFFFF_FFFF);
        tick();
        chk_rd("cyc_wrap", CYA, 32'h0);
        wr(CYA, 32'h1234, 4'b0011);
        chk_rd("cyc_partial", CYA, 32'h1);
        chk("cyc_partial_err", 32'(bus.addr_err), 32'h0);

        // Unmapped write
        drive(UNM, 32'hCAFE, 4'hF);
        #1;
        chk("unm_err_before", 32'(bus.addr_err), 32'h0);
        tick();
        bus.we_dmem = 4'h0;
        chk("unm_err_pulse", 32'(bus.addr_err), 32'h1);
        chk_rd("unm_read", UNM, 32'h0);
        tick();
        chk("unm_err_cleared", 32'(bus.addr_err), 32'h0);
        chk_rd("unm_ram_intact", 32'h10, 32'hDEAD_BEAA);

        // Asynchronous reset mid-operation
        wr(TXA, 32'h77, 4'h1);
        wr(TXA, 32'h78, 4'h1);
        chk("arst_pre_valid", 32'(bus.cons_valid), 32'h1);
        bus.daddr = CYA;
        #1;
        reset = 1'b1;
        #1;
        chk("arst_valid", 32'(bus.cons_valid), 32'h0);
        chk("arst_cycle", bus.drdata, 32'h0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        chk_rd("arst_ram", 32'h10, 32'hDEAD_BEAA);
        chk_rd("arst_status", STA, 32'h0000_0002);

        // Randomized phase against the model
        for (int i = 0; i < 16; i++) wr(32'(i * 4), $urandom, 4'hF);
        for (int n = 0; n < 400; n++) begin
            op = $urandom_range(0, 7);
            we = 4'($urandom_range(0, 15));
            case (op)
                0:       a = 32'($urandom_range(0, 63));
                1, 2:    a = TXA;
                3:       a = STA;
                4: begin
                    a  = CYA;
                    we = ($urandom_range(0, 1) == 1) ? 4'hF : we;
                end
                5:       a = ($urandom_range(0, 1) == 1) ? BASE + 32'hC : UNM + 32'($urandom_range(0, 4095));
                default: begin
                    we = 4'h0;
                    case ($urandom_range(0, 4))
                        0:       a = STA;
                        1:       a = CYA;
                        2:       a = TXA;
                        3:       a = UNM;
                        default: a = 32'($urandom_range(0, 63));
                    endcase
                end
            endcase
            drive(a, $urandom, we);
            bus.cons_ready = (n < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 1);
            #1;
            chk_model("rand");
            tick();
        end
        bus.we_dmem = 4'h0;
        #1;
        chk_model("final");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
